// File: rtl/ibf_cfg_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : ibf_cfg_loader_if
// Brief    : Host command / config-word handshake bundle for ibf_cfg_loader.
// Revision : 1.0
// ============================================================================
interface ibf_cfg_loader_if #(
    parameter int MODE_WIDTH = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_tgt;
    logic [MODE_WIDTH-1:0] cmd_mode;
    logic                  wd_valid;
    logic                  wd_ready;
    logic [63:0]           wd_data;

    modport master (
        output cmd_valid, cmd_tgt, cmd_mode, wd_valid, wd_data,
        input  cmd_ready, wd_ready
    );

    modport slave (
        input  cmd_valid, cmd_tgt, cmd_mode, wd_valid, wd_data,
        output cmd_ready, wd_ready
    );
endinterface
`default_nettype wire

// File: rtl/ibf_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : ibf_cfg_loader
// Brief    : Write sequencer streaming 64-bit config words into the ibf_top
//            2_2 stage RAM or 2_1 mux RAM, one registered beat per word.
// Revision : 1.0
// ============================================================================
module ibf_cfg_loader #(
    parameter int MODE_WIDTH = 2,
    parameter int NSEL_2_2   = 2,
    parameter int NSEL_2_1   = 1,
    parameter int GAP_CYC    = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    ibf_cfg_loader_if.slave            host,
    input  wire logic                  abort_i,
    input  wire logic [MODE_WIDTH-1:0] mode_i,
    output logic                       mode_blk_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [7:0]                 sram_sel_2_2,
    output logic [MODE_WIDTH-1:0]      wr_addr_2_2,
    output logic                       wr_en_2_2,
    output logic [63:0]                wr_cfg_2_2,
    output logic [3:0]                 sram_sel_2_1,
    output logic [MODE_WIDTH-1:0]      wr_addr_2_1,
    output logic                       wr_en_2_1,
    output logic [63:0]                wr_cfg_2_1
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [7:0] C_LAST_2_2 = 8'(NSEL_2_2 - 1);
    localparam logic [7:0] C_LAST_2_1 = 8'(NSEL_2_1 - 1);
    localparam logic [7:0] C_GAP_LAST = 8'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t                r_state;
    logic                  r_tgt;
    logic [MODE_WIDTH-1:0] r_mode;
    logic [7:0]            r_cnt;
    logic [7:0]            r_gap;

    logic w_beat;
    logic w_last;

    // Abort wins over a word offered in the same cycle.
    assign host.cmd_ready = (r_state == S_IDLE);
    assign host.wd_ready  = (r_state == S_LOAD) && !abort_i;

    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = (r_state == S_DONE);
    assign err_o      = (r_state == S_ERR);
    assign mode_blk_o = busy_o && (mode_i == r_mode);

    assign w_beat = host.wd_valid && host.wd_ready;
    assign w_last = (r_cnt == (r_tgt ? C_LAST_2_1 : C_LAST_2_2));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_tgt        <= 1'b0;
            r_mode       <= '0;
            r_cnt        <= 8'd0;
            r_gap        <= 8'd0;
            sram_sel_2_2 <= 8'd0;
            wr_addr_2_2  <= '0;
            wr_en_2_2    <= 1'b0;
            wr_cfg_2_2   <= 64'd0;
            sram_sel_2_1 <= 4'd0;
            wr_addr_2_1  <= '0;
            wr_en_2_1    <= 1'b0;
            wr_cfg_2_1   <= 64'd0;
        end else begin
            wr_en_2_2 <= 1'b0;
            wr_en_2_1 <= 1'b0;

            // Address/data hold their last values through bubbles.
            if (w_beat) begin
                r_cnt <= r_cnt + 8'd1;
                if (r_tgt) begin
                    wr_en_2_1    <= 1'b1;
                    sram_sel_2_1 <= r_cnt[3:0];
                    wr_addr_2_1  <= r_mode;
                    wr_cfg_2_1   <= host.wd_data;
                end else begin
                    wr_en_2_2    <= 1'b1;
                    sram_sel_2_2 <= r_cnt;
                    wr_addr_2_2  <= r_mode;
                    wr_cfg_2_2   <= host.wd_data;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (host.cmd_valid && host.cmd_ready) begin
                        r_state <= S_LOAD;
                        r_tgt   <= host.cmd_tgt;
                        r_mode  <= host.cmd_mode;
                        r_cnt   <= 8'd0;
                    end
                end
                S_LOAD: begin
                    if (abort_i) begin
                        r_state <= S_ERR;
                    end else if (w_beat && w_last) begin
                        r_gap   <= 8'd0;
                        r_state <= (GAP_CYC == 0) ? S_DONE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (abort_i) begin
                        r_state <= S_ERR;
                    end else if (r_gap == C_GAP_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ibf_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibf_cfg_loader
// Brief    : Directed self-checking bench for ibf_cfg_loader (two parameter sets).
// Revision : 1.0
// ============================================================================
module tb_ibf_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       abort_a, abort_b;
    logic [1:0] mode_a, mode_b;

    ibf_cfg_loader_if #(.MODE_WIDTH(2)) ifa ();
    ibf_cfg_loader_if #(.MODE_WIDTH(2)) ifb ();

    logic        a_blk, a_busy, a_done, a_err, a_en22, a_en21;
    logic [7:0]  a_sel22;
    logic [3:0]  a_sel21;
    logic [1:0]  a_addr22, a_addr21;
    logic [63:0] a_cfg22, a_cfg21;
    logic        b_blk, b_busy, b_done, b_err, b_en22, b_en21;
    logic [7:0]  b_sel22;
    logic [3:0]  b_sel21;
    logic [1:0]  b_addr22, b_addr21;
    logic [63:0] b_cfg22, b_cfg21;

    ibf_cfg_loader #(.MODE_WIDTH(2), .NSEL_2_2(2), .NSEL_2_1(1), .GAP_CYC(2)) u_dut_a (
        .clk(clk), .rst(rst), .host(ifa), .abort_i(abort_a), .mode_i(mode_a),
        .mode_blk_o(a_blk), .busy_o(a_busy), .done_o(a_done), .err_o(a_err),
        .sram_sel_2_2(a_sel22), .wr_addr_2_2(a_addr22), .wr_en_2_2(a_en22), .wr_cfg_2_2(a_cfg22),
        .sram_sel_2_1(a_sel21), .wr_addr_2_1(a_addr21), .wr_en_2_1(a_en21), .wr_cfg_2_1(a_cfg21)
    );

    ibf_cfg_loader #(.MODE_WIDTH(2), .NSEL_2_2(4), .NSEL_2_1(1), .GAP_CYC(2)) u_dut_b (
        .clk(clk), .rst(rst), .host(ifb), .abort_i(abort_b), .mode_i(mode_b),
        .mode_blk_o(b_blk), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
        .sram_sel_2_2(b_sel22), .wr_addr_2_2(b_addr22), .wr_en_2_2(b_en22), .wr_cfg_2_2(b_cfg22),
        .sram_sel_2_1(b_sel21), .wr_addr_2_1(b_addr21), .wr_en_2_1(b_en21), .wr_cfg_2_1(b_cfg21)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_tests++; if (ifa.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b expected 1", ifa.cmd_ready); end
        n_tests++; if ({a_en22, a_en21, a_busy, a_done, a_err, a_blk} !== 6'b0) begin n_fail++; $display("FAIL rst_outs: got %b expected 000000", {a_en22, a_en21, a_busy, a_done, a_err, a_blk}); end
        n_tests++; if ({ifb.cmd_ready, b_en22, b_busy} !== 3'b100) begin n_fail++; $display("FAIL rst_b: got %b expected 100", {ifb.cmd_ready, b_en22, b_busy}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_2_2_job();
        int cyc;
        logic saw21;
        ifa.cmd_valid = 1'b1; ifa.cmd_tgt = 1'b0; ifa.cmd_mode = 2'd2;
        tick(); cyc = 1;
        ifa.cmd_valid = 1'b0;
        n_tests++; if ({a_busy, ifa.cmd_ready, ifa.wd_ready} !== 3'b101) begin n_fail++; $display("FAIL t2_load_state: got %b expected 101", {a_busy, ifa.cmd_ready, ifa.wd_ready}); end
        ifa.wd_valid = 1'b1; ifa.wd_data = 64'hAAAA_0000_1111_2222;
        tick(); cyc++;
        saw21 = a_en21;
        n_tests++; if ({a_en22, a_sel22, a_addr22} !== {1'b1, 8'd0, 2'd2}) begin n_fail++; $display("FAIL t2_beat0: got %h expected %h", {a_en22, a_sel22, a_addr22}, {1'b1, 8'd0, 2'd2}); end
        n_tests++; if (a_cfg22 !== 64'hAAAA_0000_1111_2222) begin n_fail++; $display("FAIL t2_cfg0: got %h expected aaaa000011112222", a_cfg22); end
        ifa.wd_data = 64'hBBBB_3333_4444_5555;
        tick(); cyc++;
        ifa.wd_valid = 1'b0;
        saw21 |= a_en21;
        n_tests++; if ({a_en22, a_sel22, a_addr22} !== {1'b1, 8'd1, 2'd2}) begin n_fail++; $display("FAIL t2_beat1: got %h expected %h", {a_en22, a_sel22, a_addr22}, {1'b1, 8'd1, 2'd2}); end
        n_tests++; if (a_cfg22 !== 64'hBBBB_3333_4444_5555) begin n_fail++; $display("FAIL t2_cfg1: got %h expected bbbb333344445555", a_cfg22); end
        for (int i = 0; i < 10 && !a_done; i++) begin
            tick(); cyc++;
            saw21 |= a_en21;
        end
        n_tests++; if (a_done !== 1'b1 || cyc != 5) begin n_fail++; $display("FAIL t2_done_latency: got done=%b at cycle %0d expected done=1 at cycle 5", a_done, cyc); end
        n_tests++; if (saw21 !== 1'b0) begin n_fail++; $display("FAIL t2_no_2_1_write: got %b expected 0", saw21); end
        n_tests++; if ({a_en22, a_busy, a_cfg22} !== {1'b0, 1'b1, 64'hBBBB_3333_4444_5555}) begin n_fail++; $display("FAIL t2_done_cycle: got %h expected %h", {a_en22, a_busy, a_cfg22}, {1'b0, 1'b1, 64'hBBBB_3333_4444_5555}); end
        tick();
        n_tests++; if ({ifa.cmd_ready, a_busy, a_done} !== 3'b100) begin n_fail++; $display("FAIL t2_back_idle: got %b expected 100", {ifa.cmd_ready, a_busy, a_done}); end
    endtask

    task automatic test_2_1_bubble();
        logic saw;
        ifa.cmd_valid = 1'b1; ifa.cmd_tgt = 1'b1; ifa.cmd_mode = 2'd1;
        tick();
        ifa.cmd_valid = 1'b0; ifa.wd_valid = 1'b0;
        saw = 1'b0;
        repeat (3) begin tick(); saw |= a_en21 | a_en22; end
        n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL t3_bubble_no_write: got %b expected 0", saw); end
        ifa.wd_valid = 1'b1; ifa.wd_data = 64'hC0DE_CAFE_1234_5678;
        tick();
        ifa.wd_valid = 1'b0;
        n_tests++; if ({a_en21, a_sel21, a_addr21, a_en22} !== {1'b1, 4'd0, 2'd1, 1'b0}) begin n_fail++; $display("FAIL t3_beat: got %h expected %h", {a_en21, a_sel21, a_addr21, a_en22}, {1'b1, 4'd0, 2'd1, 1'b0}); end
        n_tests++; if (a_cfg21 !== 64'hC0DE_CAFE_1234_5678) begin n_fail++; $display("FAIL t3_cfg: got %h expected c0decafe12345678", a_cfg21); end
        tick();
        n_tests++; if ({a_en21, a_cfg21} !== {1'b0, 64'hC0DE_CAFE_1234_5678}) begin n_fail++; $display("FAIL t3_hold: got %h expected %h", {a_en21, a_cfg21}, {1'b0, 64'hC0DE_CAFE_1234_5678}); end
        for (int i = 0; i < 10 && !a_done; i++) tick();
        n_tests++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL t3_done: got %b expected 1", a_done); end
        tick();
        n_tests++; if (ifa.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL t3_idle: got %b expected 1", ifa.cmd_ready); end
    endtask

    task automatic test_abort();
        logic saw_done;
        ifb.cmd_valid = 1'b1; ifb.cmd_tgt = 1'b0; ifb.cmd_mode = 2'd0;
        tick();
        ifb.cmd_valid = 1'b0;
        ifb.wd_valid = 1'b1; ifb.wd_data = 64'h0000_0000_0000_0A11;
        tick();
        n_tests++; if ({b_en22, b_sel22, b_cfg22} !== {1'b1, 8'd0, 64'h0A11}) begin n_fail++; $display("FAIL t4_beat0: got %h expected %h", {b_en22, b_sel22, b_cfg22}, {1'b1, 8'd0, 64'h0A11}); end
        ifb.wd_data = 64'h0000_0000_0000_0B22; abort_b = 1'b1;
        #1;
        n_tests++; if (ifb.wd_ready !== 1'b0) begin n_fail++; $display("FAIL t4_wd_ready_abort: got %b expected 0", ifb.wd_ready); end
        tick();
        abort_b = 1'b0; ifb.wd_valid = 1'b0;
        n_tests++; if ({b_en22, b_err, b_busy, ifb.cmd_ready, b_done} !== 5'b01100) begin n_fail++; $display("FAIL t4_err_cycle: got %b expected 01100", {b_en22, b_err, b_busy, ifb.cmd_ready, b_done}); end
        tick();
        n_tests++; if ({ifb.cmd_ready, b_err, b_busy} !== 3'b100) begin n_fail++; $display("FAIL t4_idle_after_err: got %b expected 100", {ifb.cmd_ready, b_err, b_busy}); end
        saw_done = 1'b0;
        repeat (4) begin tick(); saw_done |= b_done | b_err | b_en22; end
        n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL t4_quiet_after: got %b expected 0", saw_done); end
    endtask

    task automatic test_blocking();
        mode_a = 2'd3;
        ifa.cmd_valid = 1'b1; ifa.cmd_tgt = 1'b1; ifa.cmd_mode = 2'd3;
        #1;
        n_tests++; if (a_blk !== 1'b0) begin n_fail++; $display("FAIL t5_blk_idle: got %b expected 0", a_blk); end
        tick();
        ifa.cmd_valid = 1'b0;
        n_tests++; if (a_blk !== 1'b1) begin n_fail++; $display("FAIL t5_blk_match: got %b expected 1", a_blk); end
        mode_a = 2'd0;
        #1;
        n_tests++; if (a_blk !== 1'b0) begin n_fail++; $display("FAIL t5_blk_other: got %b expected 0", a_blk); end
        mode_a = 2'd3;
        ifa.wd_valid = 1'b1; ifa.wd_data = 64'h5;
        tick();
        ifa.wd_valid = 1'b0;
        for (int i = 0; i < 10 && !a_done; i++) tick();
        n_tests++; if ({a_done, a_blk} !== 2'b11) begin n_fail++; $display("FAIL t5_blk_done: got %b expected 11", {a_done, a_blk}); end
        tick();
        n_tests++; if (a_blk !== 1'b0) begin n_fail++; $display("FAIL t5_blk_after: got %b expected 0", a_blk); end
        mode_a = 2'd0;
    endtask

    task automatic test_reset_mid_load();
        logic saw;
        ifa.cmd_valid = 1'b1; ifa.cmd_tgt = 1'b0; ifa.cmd_mode = 2'd1;
        tick();
        ifa.cmd_valid = 1'b0;
        ifa.wd_valid = 1'b1; ifa.wd_data = 64'hD;
        tick();
        n_tests++; if ({a_en22, a_sel22} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL t6_beat0: got %h expected %h", {a_en22, a_sel22}, {1'b1, 8'd0}); end
        rst = 1'b0; ifa.wd_data = 64'hE;
        tick();
        rst = 1'b1; ifa.wd_valid = 1'b0;
        n_tests++; if ({a_en22, ifa.cmd_ready, a_busy, a_blk} !== 4'b0100) begin n_fail++; $display("FAIL t6_after_rst: got %b expected 0100", {a_en22, ifa.cmd_ready, a_busy, a_blk}); end
        saw = 1'b0;
        repeat (4) begin tick(); saw |= a_en22 | a_en21 | a_done | a_err; end
        n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL t6_quiet: got %b expected 0", saw); end
        ifa.cmd_valid = 1'b1; ifa.cmd_tgt = 1'b0; ifa.cmd_mode = 2'd2;
        tick();
        ifa.cmd_valid = 1'b0;
        ifa.wd_valid = 1'b1; ifa.wd_data = 64'hF;
        tick();
        n_tests++; if ({a_en22, a_sel22, a_cfg22} !== {1'b1, 8'd0, 64'hF}) begin n_fail++; $display("FAIL t6_new_beat0: got %h expected %h", {a_en22, a_sel22, a_cfg22}, {1'b1, 8'd0, 64'hF}); end
        ifa.wd_data = 64'h10;
        tick();
        ifa.wd_valid = 1'b0;
        n_tests++; if ({a_en22, a_sel22, a_cfg22} !== {1'b1, 8'd1, 64'h10}) begin n_fail++; $display("FAIL t6_new_beat1: got %h expected %h", {a_en22, a_sel22, a_cfg22}, {1'b1, 8'd1, 64'h10}); end
        for (int i = 0; i < 10 && !a_done; i++) tick();
        n_tests++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL t6_new_done: got %b expected 1", a_done); end
        tick();
    endtask

    initial begin
        rst = 1'b0;
        abort_a = 1'b0; abort_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0;
        ifa.cmd_valid = 1'b0; ifa.cmd_tgt = 1'b0; ifa.cmd_mode = 2'd0; ifa.wd_valid = 1'b0; ifa.wd_data = 64'd0;
        ifb.cmd_valid = 1'b0; ifb.cmd_tgt = 1'b0; ifb.cmd_mode = 2'd0; ifb.wd_valid = 1'b0; ifb.wd_data = 64'd0;
        test_reset();
        test_2_2_job();
        test_2_1_bubble();
        test_abort();
        test_blocking();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
